traffic_intersection_ctrl: RTL and testbench

- Parametrised N-road intersection light controller; successor to the two-road highway/farm controller.
- Serves one road green at a time in round-robin order, skipping roads with no demand. Road 0 is the home road and rests green when no road is requesting.
- Min/max green, yellow and all-red clearance times are in seconds, counted with a built-in 1 s tick prescaler.
- Sits between the per-road vehicle sensors and the lamp drivers.

---
 rtl/traffic_pkg.sv | 19 +
 rtl/tick_prescaler.sv | 41 ++++
 rtl/traffic_intersection_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_traffic_intersection_ctrl.sv | 163 ++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared types and constants for the intersection light controllers.
//   phase_e   : controller phase, encoded as it appears on the phase output
//   LAMP_*    : per-road lamp codes {red, yellow, green}
// -----------------------------------------------------------------------------
package traffic_pkg;

    typedef enum logic [1:0] {
        PH_GREEN  = 2'b00,
        PH_YELLOW = 2'b01,
        PH_ALLRED = 2'b10
    } phase_e;

    localparam logic [2:0] LAMP_RED = 3'b100;
    localparam logic [2:0] LAMP_YEL = 3'b010;
    localparam logic [2:0] LAMP_GRN = 3'b001;

endpackage

// File: rtl/tick_prescaler.sv
// -----------------------------------------------------------------------------
// tick_prescaler
// Free-running divider producing a one-cycle tick every DIV clock cycles.
// The count runs 0..DIV-1 and tick_o is high while the count equals DIV-1.
// Ports:
//   clk_i   : clock
//   rst_i   : synchronous, active-high reset (count returns to 0)
//   tick_o  : one-cycle pulse, once per DIV cycles
// -----------------------------------------------------------------------------
module tick_prescaler #(
    parameter int DIV = 50000000
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick_o = (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (tick_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/traffic_intersection_ctrl.sv
// -----------------------------------------------------------------------------
// traffic_intersection_ctrl
// N-road intersection light controller. One road is green at a time; roads are
// served round-robin, skipping roads without a latched request. Road 0 is the
// home road and rests green while nobody else is asking.
//
// Optional build macro: TRAFFIC_PREEMPT_EN enables emergency preemption via
// preempt/preempt_road. Without it those ports are accepted and ignored.
//
// Ports:
//   clk           : system clock
//   rst           : synchronous, active-high reset
//   sensor        : per-road vehicle present (level, bit i = road i)
//   preempt       : emergency preemption request
//   preempt_road  : road to preempt to
//   lights        : per-road lamps {red,yellow,green}, road i at [3i+2:3i]
//   active_road   : road owning the current phase
//   phase         : 00 GREEN, 01 YELLOW, 10 ALL_RED
//
// States:
//   state      | meaning
//   -----------+----------------------------------------------------------
//   PH_GREEN   | active road green, all others red
//   PH_YELLOW  | active road yellow, all others red
//   PH_ALLRED  | every road red; on exit pick the next road to serve
//   (2'b11)    | illegal; recovers to PH_ALLRED with dwell cleared
// -----------------------------------------------------------------------------
module traffic_intersection_ctrl
    import traffic_pkg::*;
#(
    parameter int N_ROADS   = 4,
    parameter int TICK_DIV  = 50000000,
    parameter int MIN_GREEN = 5,
    parameter int MAX_GREEN = 12,
    parameter int YELLOW_T  = 3,
    parameter int ALLRED_T  = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [N_ROADS-1:0]           sensor,
    input  logic                         preempt,
    input  logic [$clog2(N_ROADS)-1:0]   preempt_road,
    output logic [3*N_ROADS-1:0]         lights,
    output logic [$clog2(N_ROADS)-1:0]   active_road,
    output logic [1:0]                   phase
);

    localparam int RW = $clog2(N_ROADS);
    localparam int DW = $clog2(MAX_GREEN + 1);

    // Dwell saturates at MAX_GREEN, so YELLOW_T and ALLRED_T must not exceed it.
    localparam logic [DW-1:0] MIN_G = DW'(MIN_GREEN);
    localparam logic [DW-1:0] MAX_G = DW'(MAX_GREEN);
    localparam logic [DW-1:0] YEL_T = DW'(YELLOW_T);
    localparam logic [DW-1:0] AR_T  = DW'(ALLRED_T);

    logic                tick;
    phase_e              phase_q,  phase_d;
    logic [RW-1:0]       road_q,   road_d;
    logic [DW-1:0]       dwell_q,  dwell_d;
    logic [DW-1:0]       dwell_inc;
    logic [N_ROADS-1:0]  req_q,    req_d;
    logic [N_ROADS-1:0]  own_mask;
    logic                sensor_own;
    logic                others_req;
    logic                green_exit;
    logic [RW-1:0]       rr_next;
    logic                rr_found;
    logic [RW-1:0]       rr_cand;
    logic [RW-1:0]       next_road;
    logic                pre_valid;
    logic [RW-1:0]       pre_road;

    tick_prescaler #(
        .DIV (TICK_DIV)
    ) u_prescaler (
        .clk_i  (clk),
        .rst_i  (rst),
        .tick_o (tick)
    );

`ifdef TRAFFIC_PREEMPT_EN
    // Marks which encodings of preempt_road name a real road; out-of-range
    // requests are dropped rather than aliased onto another road.
    logic [(2**RW)-1:0] road_ok;

    always_comb begin
        road_ok = '0;
        for (int k = 0; k < 2**RW; k++) begin
            road_ok[k] = (k < N_ROADS);
        end
    end

    assign pre_valid = preempt & road_ok[preempt_road];
    assign pre_road  = preempt_road;
`else
    logic unused_preempt;

    assign unused_preempt = ^{preempt, preempt_road};
    assign pre_valid      = 1'b0;
    assign pre_road       = '0;
`endif

    always_comb begin
        own_mask         = '0;
        own_mask[road_q] = 1'b1;
    end

    assign sensor_own = |(sensor & own_mask);
    assign others_req = |(req_q & ~own_mask);
    assign dwell_inc  = (dwell_q == MAX_G) ? MAX_G : dwell_q + DW'(1);

    // Round-robin search starting after the current road and wrapping back
    // to it; falls back to the home road when nothing is pending.
    always_comb begin
        rr_next  = '0;
        rr_found = 1'b0;
        rr_cand  = '0;
        for (int k = 1; k <= N_ROADS; k++) begin
            rr_cand = RW'((int'(road_q) + k) % N_ROADS);
            if (!rr_found && req_q[rr_cand]) begin
                rr_next  = rr_cand;
                rr_found = 1'b1;
            end
        end
    end

    assign next_road = pre_valid ? pre_road : rr_next;

    always_comb begin
        green_exit = 1'b0;
        if (pre_valid) begin
            // Preempted road holds regardless of MAX_GREEN; any other road
            // leaves on the very next tick, ignoring MIN_GREEN.
            green_exit = tick && (road_q != pre_road);
        end else begin
            green_exit = tick
                      && (dwell_inc >= MIN_G)
                      && (others_req || ((road_q != '0) && !sensor_own))
                      && (!sensor_own || (dwell_inc == MAX_G));
        end
    end

    always_comb begin
        phase_d = phase_q;
        road_d  = road_q;
        dwell_d = tick ? dwell_inc : dwell_q;
        // A road's own sensor is not latched while that road is green.
        req_d   = req_q | (sensor & ~((phase_q == PH_GREEN) ? own_mask : '0));

        case (phase_q)
            PH_GREEN: begin
                if (green_exit) begin
                    phase_d = PH_YELLOW;
                    dwell_d = '0;
                end
            end
            PH_YELLOW: begin
                if (tick && (dwell_inc == YEL_T)) begin
                    phase_d = PH_ALLRED;
                    dwell_d = '0;
                end
            end
            PH_ALLRED: begin
                if (tick && (dwell_inc == AR_T)) begin
                    phase_d          = PH_GREEN;
                    road_d           = next_road;
                    dwell_d          = '0;
                    req_d[next_road] = 1'b0;
                end
            end
            default: begin
                phase_d = PH_ALLRED;
                dwell_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= PH_GREEN;
            road_q  <= '0;
            dwell_q <= '0;
            req_q   <= '0;
        end else begin
            phase_q <= phase_d;
            road_q  <= road_d;
            dwell_q <= dwell_d;
            req_q   <= req_d;
        end
    end

    // Moore decode from registered state only.
    always_comb begin
        lights = {N_ROADS{LAMP_RED}};
        for (int i = 0; i < N_ROADS; i++) begin
            if (road_q == RW'(i)) begin
                case (phase_q)
                    PH_GREEN:  lights[3*i +: 3] = LAMP_GRN;
                    PH_YELLOW: lights[3*i +: 3] = LAMP_YEL;
                    default:   lights[3*i +: 3] = LAMP_RED;
                endcase
            end
        end
    end

    assign active_road = road_q;
    assign phase       = phase_q;

endmodule

// File: tb/tb_traffic_intersection_ctrl.sv
module tb_traffic_intersection_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  sensor = '0;
    logic        preempt = 1'b0;
    logic [1:0]  preempt_road = '0;
    logic [11:0] lights;
    logic [1:0]  active_road;
    logic [1:0]  phase;

    int n_run  = 0;
    int n_fail = 0;
    int cyc    = 0;

    localparam logic [11:0] L_G0 = 12'b100_100_100_001;
    localparam logic [11:0] L_Y0 = 12'b100_100_100_010;
    localparam logic [11:0] L_G1 = 12'b100_100_001_100;
    localparam logic [11:0] L_Y1 = 12'b100_100_010_100;
    localparam logic [11:0] L_G2 = 12'b100_001_100_100;
    localparam logic [11:0] L_Y2 = 12'b100_010_100_100;
    localparam logic [11:0] L_G3 = 12'b001_100_100_100;
    localparam logic [11:0] L_Y3 = 12'b010_100_100_100;
    localparam logic [11:0] L_AR = 12'b100_100_100_100;

    traffic_intersection_ctrl #(
        .N_ROADS   (4),
        .TICK_DIV  (4),
        .MIN_GREEN (5),
        .MAX_GREEN (12),
        .YELLOW_T  (3),
        .ALLRED_T  (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sensor       (sensor),
        .preempt      (preempt),
        .preempt_road (preempt_road),
        .lights       (lights),
        .active_road  (active_road),
        .phase        (phase)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @cycle %0d: got %h, expected %h", tag, cyc, got, exp);
        end
    endtask

    function automatic logic [31:0] obs();
        return {16'h0, phase, active_road, lights};
    endfunction

    function automatic logic [31:0] st(input logic [1:0] ph, input logic [1:0] ar,
                                       input logic [11:0] l);
        return {16'h0, ph, ar, l};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic go(input int target);
        while (cyc < target) step();
    endtask

    // Leaves the bench in cycle 0: prescaler count 0, rst low.
    task automatic do_reset();
        rst          = 1'b1;
        sensor       = '0;
        preempt      = 1'b0;
        preempt_road = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic pulse_sensor2_at10();
        go(10);
        sensor[2] = 1'b1;
        step();
        sensor[2] = 1'b0;
    endtask

    initial begin
        // Reset state and idle home road
        do_reset();
        chk("reset_state", obs(), st(2'd0, 2'd0, L_G0));
        chk("reset_req", 32'(dut.req_q), 32'h0);
        for (int c = 0; c < 200; c++) begin
            chk("idle_home", obs(), st(2'd0, 2'd0, L_G0));
            step();
        end

        // Single pulse on road 2, then road 2 drops back to home
        do_reset();
        pulse_sensor2_at10();
        go(19); chk("s2_g0_hold",  obs(), st(2'd0, 2'd0, L_G0));
        go(20); chk("s2_yellow0",  obs(), st(2'd1, 2'd0, L_Y0));
        go(31); chk("s2_yel_end",  obs(), st(2'd1, 2'd0, L_Y0));
        go(32); chk("s2_allred",   obs(), st(2'd2, 2'd0, L_AR));
        go(35); chk("s2_req_set",  32'(dut.req_q), 32'h4);
                chk("s2_ar_end",   obs(), st(2'd2, 2'd0, L_AR));
        go(36); chk("s2_green2",   obs(), st(2'd0, 2'd2, L_G2));
                chk("s2_req_clr",  32'(dut.req_q), 32'h0);
        go(55); chk("s4_g2_min",   obs(), st(2'd0, 2'd2, L_G2));
        go(56); chk("s4_yellow2",  obs(), st(2'd1, 2'd2, L_Y2));
        go(68); chk("s4_allred",   obs(), st(2'd2, 2'd2, L_AR));
        go(72); chk("s4_home",     obs(), st(2'd0, 2'd0, L_G0));

        // Reset in the middle of YELLOW(2)
        do_reset();
        pulse_sensor2_at10();
        go(60); chk("s5_in_yel2",  obs(), st(2'd1, 2'd2, L_Y2));
        rst = 1'b1;
        step();
        chk("s5_after_rst", obs(), st(2'd0, 2'd0, L_G0));
        chk("s5_req_rst",   32'(dut.req_q), 32'h0);
        rst = 1'b0;

        // Roads 1 and 3 held: order 0 -> 1 -> 3 -> 1, MAX_GREEN caps
        do_reset();
        sensor = 4'b1010;
        go(20);  chk("s3_yellow0",  obs(), st(2'd1, 2'd0, L_Y0));
        go(36);  chk("s3_green1",   obs(), st(2'd0, 2'd1, L_G1));
        go(83);  chk("s3_g1_tick11",obs(), st(2'd0, 2'd1, L_G1));
        go(84);  chk("s3_g1_max",   obs(), st(2'd1, 2'd1, L_Y1));
        go(96);  chk("s3_allred",   obs(), st(2'd2, 2'd1, L_AR));
        go(100); chk("s3_green3",   obs(), st(2'd0, 2'd3, L_G3));
        go(147); chk("s3_g3_hold",  obs(), st(2'd0, 2'd3, L_G3));
        go(148); chk("s3_g3_max",   obs(), st(2'd1, 2'd3, L_Y3));
        go(164); chk("s3_back_g1",  obs(), st(2'd0, 2'd1, L_G1));

        // Preemption to road 3 raised after tick 2 of GREEN(0)
        do_reset();
        go(8);
        preempt      = 1'b1;
        preempt_road = 2'd3;
`ifdef TRAFFIC_PREEMPT_EN
        go(11);  chk("s6_g0_pre",   obs(), st(2'd0, 2'd0, L_G0));
        go(12);  chk("s6_yellow0",  obs(), st(2'd1, 2'd0, L_Y0));
        go(24);  chk("s6_allred",   obs(), st(2'd2, 2'd0, L_AR));
        go(28);  chk("s6_green3",   obs(), st(2'd0, 2'd3, L_G3));
        go(118); chk("s6_g3_hold",  obs(), st(2'd0, 2'd3, L_G3));
`else
        go(12);  chk("s6_g0_a",     obs(), st(2'd0, 2'd0, L_G0));
        go(28);  chk("s6_g0_b",     obs(), st(2'd0, 2'd0, L_G0));
        go(118); chk("s6_g0_c",     obs(), st(2'd0, 2'd0, L_G0));
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
